// File: rtl/dem_tree_encoder.sv
// Tree DEM encoder: saturated binary code -> 2^CODE_W unit-element select mask, PN-steered odd splits.
// Capture stage plus one switching-block layer per clock; CODE_W cycles latency, no backpressure.
module dem_tree_encoder #(
   parameter int CODE_W = 3
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 pn_seq_i,
   input  logic                 dem_en_i,
   input  logic                 valid_i,
   input  logic [CODE_W:0]      code_i,
   output logic                 valid_o,
   output logic [2**CODE_W-1:0] elem_o,
   output logic                 sat_o
);
   localparam int NUM_EL = 2**CODE_W;
   localparam int NUM_SB = NUM_EL - 1;
   localparam logic [CODE_W:0] FULL = (CODE_W+1)'(NUM_EL);

   logic [NUM_SB-1:0] r_q, r_d;
   logic              cap_vld_q, cap_vld_d;
   logic [CODE_W:0]   cap_code_q, cap_code_d;
   logic              sat_q, sat_d;

   always_comb begin
      r_d        = {r_q[NUM_SB-2:0], pn_seq_i};
      cap_vld_d  = valid_i;
      cap_code_d = cap_code_q;
      sat_d      = sat_q;
      if (valid_i) begin
         if (code_i > FULL) begin
            cap_code_d = FULL;
            sat_d      = 1'b1;
         end else begin
            cap_code_d = code_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_q        <= '0;
         cap_vld_q  <= 1'b0;
         cap_code_q <= '0;
         sat_q      <= 1'b0;
      end else begin
         r_q        <= r_d;
         cap_vld_q  <= cap_vld_d;
         cap_code_q <= cap_code_d;
         sat_q      <= sat_d;
      end
   end

   // Layer l splits 2^l values; steer_q carries the steer bits for this layer and all deeper ones.
   for (genvar l = 0; l < CODE_W; l++) begin : g_layer
      localparam int IW  = CODE_W + 1 - l;
      localparam int OW  = CODE_W - l;
      localparam int NB  = 2**l;
      localparam int PNB = NB / 2;
      localparam int SW  = NUM_SB - NB + 1;

      logic [IW-1:0] in_val [NB];
      logic          in_vld;
      logic [SW-1:0] steer_q, steer_d;
      logic [OW-1:0] val_q [2*NB];
      logic [OW-1:0] val_d [2*NB];
      logic          vld_q, vld_d;

      if (l == 0) begin : g_src
         assign in_val[0] = cap_code_q;
         assign in_vld    = cap_vld_q;
         assign steer_d   = valid_i ? (dem_en_i ? r_q : '1) : steer_q;
      end else begin : g_src
         assign in_val  = g_layer[l-1].val_q;
         assign in_vld  = g_layer[l-1].vld_q;
         assign steer_d = g_layer[l-1].in_vld ? g_layer[l-1].steer_q[NUM_SB-PNB:PNB] : steer_q;
      end

      // Odd value: the extra unit goes to the upper child when the steer bit is 1.
      always_comb begin
         vld_d = in_vld;
         val_d = val_q;
         if (in_vld) begin
            for (int b = 0; b < NB; b++) begin
               val_d[2*b+1] = in_val[b][IW-1:1] + OW'(in_val[b][0] & steer_q[b]);
               val_d[2*b]   = OW'(in_val[b] - IW'(val_d[2*b+1]));
            end
         end
      end

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            vld_q   <= 1'b0;
            val_q   <= '{default: '0};
            steer_q <= '0;
         end else begin
            vld_q   <= vld_d;
            val_q   <= val_d;
            steer_q <= steer_d;
         end
      end
   end

   always_comb begin
      valid_o = g_layer[CODE_W-1].vld_q;
      for (int i = 0; i < NUM_EL; i++) begin
         elem_o[i] = g_layer[CODE_W-1].val_q[i][0];
      end
   end

   assign sat_o = sat_q;

endmodule

// File: doc/dem_tree_encoder.md
Name: dem_tree_encoder

Overview:
- Tree-structured dynamic-element-matching encoder for the DEM-DAC datapath, one stage downstream of the PN sequence generator.
- Consumes the serial PN bit stream and converts each binary input code into a 2^CODE_W-bit unit-element select mask.
- The mask popcount always equals the (saturated) input code; odd remainders are steered by PN bits at each switching block.
- Pipelined, one layer per clock, one sample accepted per cycle; feeds the unit-element DAC drivers.

Parameters:
- CODE_W, 3: number of tree layers. Unit elements = 2^CODE_W; switching blocks NUM_SB = 2^CODE_W-1 (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- pn_seq_i  in  1  serial PN bit, one new bit per clock.
- dem_en_i  in  1  1 = randomize from PN; 0 = deterministic (all steer bits forced to 1). Sampled with the data.
- valid_i  in  1  input code valid; no backpressure, accepted every cycle it is high.
- code_i  in  CODE_W+1  input code, legal range 0..2^CODE_W.
- valid_o  out  1  elem_o updated this cycle.
- elem_o  out  2^CODE_W  unit-element select mask.
- sat_o  out  1  sticky flag: some accepted code exceeded 2^CODE_W.

Behaviour:
- Reset:
  - Synchronous, active high; takes priority over all other activity.
  - Clears elem_o=0, valid_o=0, sat_o=0, the PN collector R=0, all pipeline valids and data.
  - Any sample in flight is discarded; no valid_o follows a reset.
- PN collector:
  - R[NUM_SB-1:0] shifts every clock, including when valid_i=0: R <= {R[NUM_SB-2:0], pn_seq_i}.
- Capture stage, edge t with valid_i=1:
  - Code saturated to min(code_i, 2^CODE_W); sat_o set if code_i > 2^CODE_W.
  - Steer snapshot S = dem_en_i ? R : all-ones, using R's pre-shift (registered) value at edge t.
  - Stored alongside the saturated code.
- Switching-block numbering (heap order):
  - Layer L (0..CODE_W-1) holds blocks 2^L-1 .. 2^(L+1)-2 and uses steer bits S[2^L-1 .. 2^(L+1)-2].
  - Within a layer, block index increases from element-index low to high.
  - The upper child covers the higher element indices.
- Switching-block rule, value x with steer bit s:
  - x even: upper = lower = x/2.
  - x odd: upper = (x+1)/2 if s=1, else (x-1)/2.
  - lower = x - upper.
  - Widths shrink by one bit per layer; leaf values are 0/1 and map directly to elem_o[i].
- Pipeline:
  - Capture at edge t, layer L result registered at edge t+1+L.
  - The last layer drives elem_o/valid_o, so the result is visible after edge t+CODE_W.
  - For CODE_W=3: capture at edge 10 -> valid_o high between edges 13 and 14.
- Output hold:
  - valid_o is high exactly one cycle per accepted sample.
  - elem_o holds its last value while valid_o=0.
  - Back-to-back samples produce back-to-back outputs in order, with no bubbles.
- Invariants:
  - popcount(elem_o) == saturated code whenever valid_o=1.
  - sat_o is cleared only by reset_i.
- dem_en_i toggling mid-stream affects only samples captured after the change; in-flight samples keep their snapshot.

Test Plan:
- Reset, then dem_en_i=0, code_i=5, one valid_i -> valid_o exactly 3 cycles after capture, elem_o=8'hEA, sat_o=0.
- dem_en_i=1, pn_seq_i held 0 for ≥7 cycles, then code_i=5 -> elem_o=8'h57.
- code_i=0 -> elem_o=8'h00; code_i=8 -> elem_o=8'hFF; code_i=12 -> elem_o=8'hFF and sat_o=1, still 1 after 20 further idle cycles.
- Back-to-back valid_i with codes 0..8 under a live PN stream -> 9 consecutive valid_o pulses in order, each popcount equal to its code; a reference model using the same R snapshot matches bit-exactly.
- Issue 3 samples, assert reset_i for 1 cycle while they are in flight -> no valid_o afterwards, elem_o=0, sat_o=0; a new sample after reset emerges with normal latency.
- dem_en_i=1 with pn_seq_i random for 10k samples of code 4 -> each element selected 50%±2% of samples (first-order mismatch shaping sanity).
